// File: rtl/pipe_pkg.sv
// +----------------------------------------------------------------------+
// | pipe_pkg: shared widths, NOP encoding, skid-stage state and entry.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package pipe_pkg;

   localparam int          C_XLEN     = 32;
   localparam int          C_ILEN     = 32;
   localparam int          C_SB_W     = 2;
   localparam logic [31:0] C_NOP_INST = 32'h00000013;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_TWO   = 2'd2
   } state_t;

   typedef struct packed {
      logic [C_XLEN-1:0] pc;
      logic [C_ILEN-1:0] inst;
      logic [C_SB_W-1:0] sb;
   } entry_t;

endpackage

`default_nettype wire

// File: rtl/pipe_sat_cnt.sv
// +----------------------------------------------------------------------+
// | pipe_sat_cnt: parametrised-width counter that sticks at all-ones.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module pipe_sat_cnt #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (inc && (r_count != {WIDTH{1'b1}})) begin
         r_count <= r_count + c_one;
      end
   end

   assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/if_id_skid_reg.sv
// +----------------------------------------------------------------------+
// | if_id_skid_reg: 2-entry elastic IF/ID stage (main + skid slot) with   |
// | registered in_ready and synchronous flush. IF_ID_PERF_EN adds         |
// | saturating stall/flush counters.                                      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module if_id_skid_reg
   import pipe_pkg::*;
#(
   parameter int               XLEN     = C_XLEN,
   parameter int               ILEN     = C_ILEN,
   parameter int               SB_W     = C_SB_W,
   parameter logic [ILEN-1:0]  NOP_INST = C_NOP_INST[ILEN-1:0]
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [ILEN-1:0] in_inst,
   input  logic [SB_W-1:0] in_sb,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [ILEN-1:0] out_inst,
   output logic [SB_W-1:0] out_sb
`ifdef IF_ID_PERF_EN
   ,
   output logic [31:0]     stall_cnt,
   output logic [15:0]     flush_cnt
`endif
);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] inst;
      logic [SB_W-1:0] sb;
   } slot_t;

   state_t r_state;
   state_t w_state_nxt;
   slot_t  r_main;
   slot_t  r_skid;
   slot_t  w_main_nxt;
   slot_t  w_skid_nxt;
   slot_t  w_in_slot;
   logic   r_in_ready;
   logic   w_valid;
   logic   w_acc;
   logic   w_pop;

   assign w_in_slot = '{pc: in_pc, inst: in_inst, sb: in_sb};
   assign w_valid   = (r_state != S_EMPTY);
   assign w_acc     = in_valid & r_in_ready;
   assign w_pop     = w_valid & out_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_main_nxt  = r_main;
      w_skid_nxt  = r_skid;
      if (flush) begin
         // Payload registers keep their contents so out_pc holds while invalid.
         w_state_nxt = S_EMPTY;
      end else begin
         case (r_state)
            S_EMPTY: begin
               if (w_acc) begin
                  w_main_nxt  = w_in_slot;
                  w_state_nxt = S_ONE;
               end
            end
            S_ONE: begin
               if (w_acc && w_pop) begin
                  w_main_nxt = w_in_slot;
               end else if (w_acc) begin
                  w_skid_nxt  = w_in_slot;
                  w_state_nxt = S_TWO;
               end else if (w_pop) begin
                  w_state_nxt = S_EMPTY;
               end
            end
            S_TWO: begin
               if (w_pop) begin
                  w_main_nxt  = r_skid;
                  w_state_nxt = S_ONE;
               end
            end
            default: begin
               w_state_nxt = S_EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_EMPTY;
         r_main     <= '{pc: '0, inst: NOP_INST, sb: '0};
         r_skid     <= '0;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_main     <= w_main_nxt;
         r_skid     <= w_skid_nxt;
         r_in_ready <= (w_state_nxt != S_TWO);
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = w_valid;
   assign out_pc    = r_main.pc;
   assign out_inst  = w_valid ? r_main.inst : NOP_INST;
   assign out_sb    = w_valid ? r_main.sb : '0;

`ifdef IF_ID_PERF_EN
   pipe_sat_cnt #(.WIDTH(32)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_valid & ~out_ready),
      .count (stall_cnt)
   );

   pipe_sat_cnt #(.WIDTH(16)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (flush),
      .count (flush_cnt)
   );
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_id_skid_reg.sv
// +----------------------------------------------------------------------+
// | tb_if_id_skid_reg: directed plus random traffic against a queue model.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_if_id_skid_reg;

   localparam logic [31:0] c_nop = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_inst;
   logic [1:0]  in_sb;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic [1:0]  out_sb;
`ifdef IF_ID_PERF_EN
   logic [31:0] stall_cnt;
   logic [15:0] flush_cnt;
`endif

   if_id_skid_reg dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pc     (in_pc),
      .in_inst   (in_inst),
      .in_sb     (in_sb),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_inst  (out_inst),
      .out_sb    (out_sb)
`ifdef IF_ID_PERF_EN
      ,
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [1:0]  sb;
   } ent_t;

   ent_t        mq[$];
   logic        m_ready;
   logic [31:0] m_last_pc;
   int          m_stall;
   int          m_flush;
   int          n_checks = 0;
   int          n_err    = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Model: the stage is a FIFO of depth 2; the head is what decode sees.
   task automatic tick();
      bit   acc;
      bit   pop;
      ent_t e;
      acc = in_valid && m_ready;
      pop = (mq.size() > 0) && out_ready;
      e.pc = in_pc; e.inst = in_inst; e.sb = in_sb;
      @(posedge clk);
      #1;
      if (rst) begin
         mq.delete();
         m_last_pc = 32'h0;
         m_stall   = 0;
         m_flush   = 0;
      end else begin
         if ((mq.size() > 0) && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall++;
         if (flush && m_flush != 16'hFFFF) m_flush++;
         if (flush) begin
            mq.delete();
         end else begin
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(e);
         end
      end
      m_ready = (mq.size() < 2);
      if (mq.size() > 0) m_last_pc = mq[0].pc;
      chk("in_ready",  {63'd0, in_ready},  {63'd0, m_ready});
      chk("out_valid", {63'd0, out_valid}, {63'd0, mq.size() > 0});
      chk("out_pc",    {32'd0, out_pc},    {32'd0, m_last_pc});
      chk("out_inst",  {32'd0, out_inst},  {32'd0, (mq.size() > 0) ? mq[0].inst : c_nop});
      chk("out_sb",    {62'd0, out_sb},    {62'd0, (mq.size() > 0) ? mq[0].sb : 2'b00});
`ifdef IF_ID_PERF_EN
      chk("stall_cnt", {32'd0, stall_cnt}, {32'd0, m_stall[31:0]});
      chk("flush_cnt", {48'd0, flush_cnt}, {48'd0, m_flush[15:0]});
`endif
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst, input logic [1:0] sb);
      in_valid = v;
      in_pc    = pc;
      in_inst  = inst;
      in_sb    = sb;
   endtask

   initial begin
      m_ready = 1'b1; m_last_pc = 32'h0; m_stall = 0; m_flush = 0;
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
      drive(1'b1, 32'hDEAD_0000, 32'h1111_1111, 2'b11);

      // reset with in_valid high
      tick(); tick();
      chk("reset_nop", {32'd0, out_inst}, {32'd0, 32'h00000013});
      rst = 1'b0;

      // streaming
      out_ready = 1'b1;
      drive(1'b1, 32'h0, 32'hA000_0001, 2'b01); tick();
      drive(1'b1, 32'h4, 32'hA000_0002, 2'b10); tick();
      drive(1'b1, 32'h8, 32'hA000_0003, 2'b00); tick();
      drive(1'b0, 32'h0, 32'h0, 2'b00); tick();
      tick();

      // skid fill then drain
      out_ready = 1'b0;
      drive(1'b1, 32'h100, 32'hB000_0001, 2'b01); tick();
      drive(1'b1, 32'h104, 32'hB000_0002, 2'b10); tick();
      chk("skid_full_ready", {63'd0, in_ready}, 64'd0);
      drive(1'b0, 32'h0, 32'h0, 2'b00); tick();
      out_ready = 1'b1; tick();
      chk("drain_pc0", {32'd0, out_pc}, {32'd0, 32'h104});
      tick();

      // flush while full, with a competing push
      out_ready = 1'b0;
      drive(1'b1, 32'h110, 32'hC000_0001, 2'b00); tick();
      drive(1'b1, 32'h114, 32'hC000_0002, 2'b01); tick();
      flush = 1'b1; drive(1'b1, 32'h200, 32'hC000_0003, 2'b11); tick();
      flush = 1'b0; drive(1'b0, 32'h0, 32'h0, 2'b00);
      chk("flush_valid", {63'd0, out_valid}, 64'd0);
      out_ready = 1'b1; tick();

      // stability under backpressure, from a fresh reset
      rst = 1'b1; tick(); rst = 1'b0;
      out_ready = 1'b0;
      drive(1'b1, 32'h300, 32'h00500093, 2'b01); tick();
      drive(1'b0, 32'h0, 32'h0, 2'b00);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("hold_pc", {32'd0, out_pc}, {32'd0, 32'h300});
         chk("hold_inst", {32'd0, out_inst}, {32'd0, 32'h00500093});
      end
`ifdef IF_ID_PERF_EN
      chk("stall5", {32'd0, stall_cnt}, 64'd5);
`endif

      // reset while full overrides flush and pop
      drive(1'b1, 32'h304, 32'h0000_0001, 2'b10); tick();
      rst = 1'b1; flush = 1'b1; out_ready = 1'b1; tick();
      rst = 1'b0; flush = 1'b0;
      chk("rst_mid_pc", {32'd0, out_pc}, 64'd0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         rst       = ($urandom_range(0, 63) == 0);
         flush     = ($urandom_range(0, 15) == 0);
         out_ready = $urandom_range(0, 1);
         drive($urandom_range(0, 3) != 0, $urandom, $urandom, 2'($urandom_range(0, 3)));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
